i2c_master_arbiter: RTL

- Shares one I2C write master among NUM_REQ on-chip requesters.
- Each requester presents a slave address, a register address and a data byte.
- The arbiter picks one requester round-robin, latches its fields and drives the master's start/w_en/data/s_addr/r_addr inputs. It then waits for master completion, with a watchdog timeout, and returns a per-requester done/err pulse.
- Sits between the register-bank clients and the master instance in the I2C subsystem.

---
 rtl/i2c_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/i2c_master_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C master arbiter.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    localparam int BYTE_W = 8;

    // Width of the WAIT watchdog counter; it must hold TIMEOUT-1.
    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic found;
    int   k;

    // Scan from the pointer upward; the first hit owns the grant.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[IDX_W'(k)]) begin
                found              = 1'b1;
                gnt_oh[IDX_W'(k)]  = 1'b1;
                gnt_idx            = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C write master among NUM_REQ requesters, round-robin,
// with a watchdog on the master's completion.
//
// state  | meaning
// IDLE   | no owner; arbitrate whenever any req is set
// LAUNCH | winner latched onto m_*; start pulse is being registered
// WAIT   | master running (m_start visible in first cycle); watchdog counts
// RESP   | done/err pulse to the winner; pointer advances
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_w_en,
    input  logic [NUM_REQ*BYTE_W-1:0] req_s_addr,
    input  logic [NUM_REQ*BYTE_W-1:0] req_r_addr,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        err,
    output logic                      busy,
    output logic                      m_start,
    output logic                      m_w_en,
    output logic [BYTE_W-1:0]         m_data,
    output logic [BYTE_W-1:0]         m_s_addr,
    output logic [BYTE_W-1:0]         m_r_addr,
    input  logic                      m_done,
    input  logic                      m_nack
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   rr_idx;
    logic [NUM_REQ-1:0] rr_oh;
    logic [CNT_W-1:0]   cnt;
    logic               err_flag;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (req),
        .ptr     (ptr),
        .gnt_oh  (rr_oh),
        .gnt_idx (rr_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; m_done wins over the watchdog on the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (|req) state_nxt = ST_LAUNCH;
            ST_LAUNCH: state_nxt = ST_WAIT;
            ST_WAIT:   if (m_done || (cnt == CNT_LAST)) state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Grant latch, master fields, watchdog and pointer; fields freeze until IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt      <= '0;
            win_idx  <= '0;
            ptr      <= '0;
            cnt      <= '0;
            err_flag <= 1'b0;
            m_start  <= 1'b0;
            m_w_en   <= 1'b0;
            m_data   <= '0;
            m_s_addr <= '0;
            m_r_addr <= '0;
        end else begin
            m_start <= (state == ST_LAUNCH);
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt      <= rr_oh;
                        win_idx  <= rr_idx;
                        m_w_en   <= req_w_en[rr_idx];
                        m_data   <= req_data[int'(rr_idx)*BYTE_W +: BYTE_W];
                        m_s_addr <= req_s_addr[int'(rr_idx)*BYTE_W +: BYTE_W];
                        m_r_addr <= req_r_addr[int'(rr_idx)*BYTE_W +: BYTE_W];
                    end
                end
                ST_LAUNCH: begin
                    cnt      <= '0;
                    err_flag <= 1'b0;
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (m_done)                err_flag <= m_nack;
                    else if (cnt == CNT_LAST)  err_flag <= 1'b1;
                end
                ST_RESP: begin
                    gnt <= '0;
                    ptr <= (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_RESP) ? gnt : '0;
    assign err  = ((state == ST_RESP) && err_flag) ? gnt : '0;

endmodule
